collision_scanner: RTL and testbench
====================================

COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 The module SHALL have parameter TILE_SIZE, default 32, meaning the frog and car sprite width and height in pixels.
REQ-002 The module SHALL have parameter NUM_CARS, default 8, range 1..32, meaning the number of cars checked per scan.
REQ-003 The module SHALL have parameter NUM_LANES, default 4, range 1..NUM_CARS, meaning the number of road lanes.
REQ-004 The module SHALL have parameter LANE_Y0, default 64, meaning the top Y pixel of lane 0.
REQ-005 The module SHALL have parameter LANE_PITCH, default 32, meaning the Y distance between adjacent lanes.
REQ-006 The module SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port i_Rst_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port i_Start, input, 1 bit: one-cycle scan request, typically at frame start.
REQ-009 The module SHALL have port i_Frog_X, input, 10 bits: frog top-left X.
REQ-010 The module SHALL have port i_Frog_Y, input, 9 bits: frog top-left Y.
REQ-011 The module SHALL have port i_Car_X, input, NUM_CARS*10 bits: packed car top-left X values; car k occupies bits [10k+9:10k].
REQ-012 The module SHALL have port o_Busy, output, 1 bit: high while a scan is in progress.
REQ-013 The module SHALL have port o_Done, output, 1 bit: one-cycle pulse marking the end of a scan.
REQ-014 The module SHALL have port o_Has_Collided, output, 1 bit: collision result of the last completed scan.
REQ-015 The module SHALL have port o_Hit_Index, output, 5 bits: lowest car index that collided in the last scan; 0 when there is no hit.

Function
REQ-016 The module SHALL implement the states IDLE, SCAN and DONE.
REQ-017 In IDLE, i_Start=1 SHALL snapshot i_Frog_X, i_Frog_Y and all i_Car_X values, clear the internal hit accumulator, set index=0 and go to SCAN.
REQ-018 In SCAN, the module SHALL evaluate exactly one car per cycle, index 0..NUM_CARS-1, using snapshot values only.
REQ-019 Car k SHALL have Y = LANE_Y0 + (k mod NUM_LANES)*LANE_PITCH.
REQ-020 A hit SHALL be defined as strict AABB overlap: fx < cx+TILE_SIZE and fx+TILE_SIZE > cx and fy < cy+TILE_SIZE and fy+TILE_SIZE > cy.
REQ-021 All overlap sums SHALL be computed 11 bits wide (X) and 10 bits wide (Y) so that no addition wraps.
REQ-022 On the first hit of a scan, the module SHALL record index k, and later hits in the same scan SHALL NOT overwrite it.
REQ-023 After index NUM_CARS-1 is evaluated, the module SHALL go to DONE.
REQ-024 DONE SHALL last one cycle: o_Done=1, o_Has_Collided and o_Hit_Index are updated from the accumulator, then the module returns to IDLE.
REQ-025 Latency from the i_Start cycle to the o_Done cycle SHALL be NUM_CARS+1 clocks.
REQ-026 o_Busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-027 i_Start SHALL be ignored while o_Busy=1; it is neither queued nor allowed to restart the scan.
REQ-028 i_Start asserted in the cycle of o_Done SHALL be ignored, and a new scan SHALL begin only from IDLE.
REQ-029 o_Has_Collided and o_Hit_Index SHALL hold their values between scans.

Reset
REQ-030 While i_Rst_N=0, state SHALL be IDLE, index 0 and accumulator 0, and o_Busy, o_Done, o_Has_Collided and o_Hit_Index SHALL all be 0, asynchronously.
REQ-031 Reset during SCAN SHALL abort the scan with no o_Done pulse and no output update.
REQ-032 After reset release, the first i_Start edge in IDLE SHALL start a normal scan.

Configuration
REQ-033 With macro COLLISION_STICKY_EN defined, o_Has_Collided SHALL be set by any scan with a hit and cleared only by reset.
REQ-034 With COLLISION_STICKY_EN defined, o_Hit_Index SHALL hold the index of the first hit since reset.
REQ-035 Without COLLISION_STICKY_EN, o_Has_Collided and o_Hit_Index SHALL reflect only the last completed scan, per REQ-024.

Verification
REQ-036 Defaults, frog (100,64), car0 X=80, other cars X=600 -> o_Done 9 clocks after i_Start, o_Has_Collided=1, o_Hit_Index=0.
REQ-037 Frog (100,64), car0 X=132 -> no hit; rerun with car0 X=131 -> hit (edge of strict overlap).
REQ-038 Frog (1010,96), car1 X=1000 (lane 1, Y=96) -> hit with no wrap, o_Hit_Index=1; car1 X=5 -> no hit.
REQ-039 Cars 2 and 6 both overlapping the frog -> o_Hit_Index=2; i_Start pulsed at clocks 3 and 9 of the scan -> single o_Done, no restart.
REQ-040 i_Rst_N=0 at scan clock 4 -> o_Busy=0 immediately, no o_Done, o_Has_Collided=0; next scan completes normally.
REQ-041 With COLLISION_STICKY_EN: a hit scan followed by a clean scan -> o_Has_Collided stays 1 until reset.

Source files
------------

// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - scan request/result bundle for collision_scanner
//
// Purpose : groups the scan request inputs and the scan result outputs.
// Signals : i_Start         scan request (one cycle)
//           i_Frog_X        frog top-left X (10 bits)
//           i_Frog_Y        frog top-left Y (9 bits)
//           i_Car_X         packed car top-left X, car k at [10k+9:10k]
//           o_Busy          scan in progress (SCAN or DONE)
//           o_Done          one-cycle end-of-scan pulse
//           o_Has_Collided  result of the last completed scan
//           o_Hit_Index     lowest colliding car index, 0 when no hit
// Modports: master drives the request, slave is the scanner.
interface collision_scanner_if #(
    parameter int NUM_CARS = 8
);
    logic                     i_Start;
    logic [9:0]               i_Frog_X;
    logic [8:0]               i_Frog_Y;
    logic [NUM_CARS*10-1:0]   i_Car_X;
    logic                     o_Busy;
    logic                     o_Done;
    logic                     o_Has_Collided;
    logic [4:0]               o_Hit_Index;

    modport master (
        output i_Start, i_Frog_X, i_Frog_Y, i_Car_X,
        input  o_Busy, o_Done, o_Has_Collided, o_Hit_Index
    );

    modport slave (
        input  i_Start, i_Frog_X, i_Frog_Y, i_Car_X,
        output o_Busy, o_Done, o_Has_Collided, o_Hit_Index
    );
endinterface

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - sequential frog/car AABB collision scanner
//
// Purpose : on i_Start, snapshots the frog and car positions and tests one
//           car per clock for strict bounding-box overlap with the frog.
//           The lowest colliding index and a hit flag are published with
//           a one-cycle o_Done pulse, NUM_CARS+1 clocks after i_Start.
// Ports   : i_Clk   - clock, rising edge
//           i_Rst_N - asynchronous active-low reset
//           bus     - collision_scanner_if.slave (request in, result out)
// Config  : COLLISION_STICKY_EN - when defined, o_Has_Collided latches any
//           hit until reset and o_Hit_Index keeps the first hit since reset.
module collision_scanner #(
    parameter int TILE_SIZE  = 32,
    parameter int NUM_CARS   = 8,
    parameter int NUM_LANES  = 4,
    parameter int LANE_Y0    = 64,
    parameter int LANE_PITCH = 32
) (
    input logic                i_Clk,
    input logic                i_Rst_N,
    collision_scanner_if.slave bus
);

    localparam int          IDX_W     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [4:0]  LAST_IDX  = 5'(NUM_CARS - 1);
    localparam logic [4:0]  LAST_LANE = 5'(NUM_LANES - 1);
    localparam logic [10:0] TILE_X    = 11'(TILE_SIZE);
    localparam logic [9:0]  TILE_Y    = 10'(TILE_SIZE);
    localparam logic [9:0]  Y0        = 10'(LANE_Y0);
    localparam logic [9:0]  PITCH     = 10'(LANE_PITCH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_index;
    logic [4:0]  r_lane;
    logic [9:0]  r_car_y;
    logic [9:0]  r_frog_x;
    logic [8:0]  r_frog_y;
    logic [9:0]  r_car_x [NUM_CARS];
    logic        r_acc_hit;
    logic [4:0]  r_acc_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_has_collided;
    logic [4:0]  r_hit_index;

    logic [9:0]  w_car_x;
    logic [10:0] w_fx;
    logic [10:0] w_cx;
    logic [9:0]  w_fy;
    logic        w_hit;
    logic        w_final_hit;
    logic [4:0]  w_final_idx;

    // Widened operands: X sums need 11 bits and Y sums 10 bits so that a
    // frog or car near the right/bottom edge cannot wrap into a false hit.
    assign w_car_x = r_car_x[r_index[IDX_W-1:0]];
    assign w_fx    = {1'b0, r_frog_x};
    assign w_cx    = {1'b0, w_car_x};
    assign w_fy    = {1'b0, r_frog_y};

    assign w_hit = (w_fx < (w_cx + TILE_X)) && ((w_fx + TILE_X) > w_cx) &&
                   (w_fy < (r_car_y + TILE_Y)) && ((w_fy + TILE_Y) > r_car_y);

    // Result including the car being evaluated in the final SCAN cycle; an
    // earlier hit always wins so the lowest index is kept.
    assign w_final_hit = r_acc_hit | w_hit;
    assign w_final_idx = r_acc_hit ? r_acc_idx : (w_hit ? r_index : 5'd0);

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_state        <= S_IDLE;
            r_index        <= 5'd0;
            r_lane         <= 5'd0;
            r_car_y        <= Y0;
            r_frog_x       <= 10'd0;
            r_frog_y       <= 9'd0;
            for (int k = 0; k < NUM_CARS; k++) begin
                r_car_x[k] <= 10'd0;
            end
            r_acc_hit      <= 1'b0;
            r_acc_idx      <= 5'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_has_collided <= 1'b0;
            r_hit_index    <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_Start) begin
                        r_frog_x <= bus.i_Frog_X;
                        r_frog_y <= bus.i_Frog_Y;
                        for (int k = 0; k < NUM_CARS; k++) begin
                            r_car_x[k] <= bus.i_Car_X[10*k +: 10];
                        end
                        r_acc_hit <= 1'b0;
                        r_acc_idx <= 5'd0;
                        r_index   <= 5'd0;
                        r_lane    <= 5'd0;
                        r_car_y   <= Y0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (w_hit && !r_acc_hit) begin
                        r_acc_hit <= 1'b1;
                        r_acc_idx <= r_index;
                    end
                    // Lane Y is stepped incrementally instead of computing
                    // (k mod NUM_LANES) * LANE_PITCH every cycle.
                    if (r_lane == LAST_LANE) begin
                        r_lane  <= 5'd0;
                        r_car_y <= Y0;
                    end else begin
                        r_lane  <= r_lane + 5'd1;
                        r_car_y <= r_car_y + PITCH;
                    end
                    if (r_index == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`ifdef COLLISION_STICKY_EN
                        if (!r_has_collided) begin
                            r_has_collided <= w_final_hit;
                            r_hit_index    <= w_final_idx;
                        end
`else
                        r_has_collided <= w_final_hit;
                        r_hit_index    <= w_final_idx;
`endif
                    end else begin
                        r_index <= r_index + 5'd1;
                    end
                end

                S_DONE: begin
                    // i_Start is not looked at here; a new scan needs IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Busy         = r_busy;
    assign bus.o_Done         = r_done;
    assign bus.o_Has_Collided = r_has_collided;
    assign bus.o_Hit_Index    = r_hit_index;

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - self-checking bench for collision_scanner
module tb_collision_scanner;

    localparam int NC    = 8;
    localparam int NL    = 4;
    localparam int TILE  = 32;
    localparam int LY0   = 64;
    localparam int PITCH = 32;
`ifdef COLLISION_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    collision_scanner_if #(.NUM_CARS(NC)) bus ();

    collision_scanner #(
        .TILE_SIZE (TILE),
        .NUM_CARS  (NC),
        .NUM_LANES (NL),
        .LANE_Y0   (LY0),
        .LANE_PITCH(PITCH)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_N(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: scan all cars with plain integer geometry.
    function automatic void model_scan(input int fx, input int fy,
                                       input logic [NC*10-1:0] cars,
                                       output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < NC; k++) begin
            int cx, cy;
            cx = int'(cars[k*10 +: 10]);
            cy = LY0 + (k % NL) * PITCH;
            if (!hit && fx < cx + TILE && fx + TILE > cx &&
                fy < cy + TILE && fy + TILE > cy) begin
                hit = 1'b1;
                idx = k;
            end
        end
    endfunction

    function automatic logic [NC*10-1:0] cars_with(input int dflt,
                                                   input int k1, input int x1,
                                                   input int k2, input int x2);
        logic [NC*10-1:0] v;
        for (int k = 0; k < NC; k++) v[k*10 +: 10] = 10'(dflt);
        if (k1 >= 0) v[k1*10 +: 10] = 10'(x1);
        if (k2 >= 0) v[k2*10 +: 10] = 10'(x2);
        return v;
    endfunction

    // Timeline model: a scan accepted at a clock edge is busy for NUM_CARS+1
    // cycles, with the result appearing alongside done in the last of them.
    bit m_active, m_done, m_hc, m_res_hit;
    int m_age, m_hi, m_res_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_done = 1'b0; m_hc = 1'b0; m_hi = 0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == NC) begin
                    m_done = 1'b1;
                    if (!STICKY || !m_hc) begin
                        m_hc = m_res_hit;
                        m_hi = m_res_idx;
                    end
                end else if (m_age > NC) begin
                    m_active = 1'b0;
                end
            end else if (bus.i_Start) begin
                model_scan(int'(bus.i_Frog_X), int'(bus.i_Frog_Y), bus.i_Car_X,
                           m_res_hit, m_res_idx);
                m_active = 1'b1;
                m_age    = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(bus.o_Busy), int'(m_active));
        check("done", int'(bus.o_Done), int'(m_done));
        check("has_collided", int'(bus.o_Has_Collided), int'(m_hc));
        check("hit_index", int'(bus.o_Hit_Index), m_hi);
    end

    task automatic run_scan(input string tag, input int fx, input int fy,
                            input logic [NC*10-1:0] cars, input bit extra,
                            input int exp_hc, input int exp_hi);
        int lat, n_done, act_hc, act_hi;
        lat = -1; n_done = 0; act_hc = -1; act_hi = -1;
        @(negedge clk);
        bus.i_Frog_X = 10'(fx);
        bus.i_Frog_Y = 9'(fy);
        bus.i_Car_X  = cars;
        bus.i_Start  = 1'b1;
        @(negedge clk);
        bus.i_Start  = 1'b0;
        // Live inputs change after the request; only the snapshot may count.
        bus.i_Frog_X = 10'd500;
        bus.i_Frog_Y = 9'd200;
        bus.i_Car_X  = cars_with(500, -1, 0, -1, 0);
        for (int c = 1; c <= NC + 4; c++) begin
            if (c > 1) @(negedge clk);
            bus.i_Start = extra && (c == 3 || c == 9);
            if (bus.o_Done) begin
                n_done++;
                if (lat < 0) begin
                    lat    = c;
                    act_hc = int'(bus.o_Has_Collided);
                    act_hi = int'(bus.o_Hit_Index);
                end
            end
        end
        bus.i_Start = 1'b0;
        check({tag, "_latency"}, lat, 9);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_hit"}, act_hc, exp_hc);
        check({tag, "_index"}, act_hi, exp_hi);
    endtask

    initial begin
        bit h;
        int ix, n_done;
        bus.i_Start  = 1'b0;
        bus.i_Frog_X = '0;
        bus.i_Frog_Y = '0;
        bus.i_Car_X  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.o_Busy), 0);
        check("rst_hit", int'(bus.o_Has_Collided), 0);
        check("rst_index", int'(bus.o_Hit_Index), 0);
        rst_n = 1'b1;

        model_scan(100, 64, cars_with(600, 0, 80, -1, 0), h, ix);
        check("model_pin_hit0", int'(h), 1);
        check("model_pin_idx0", ix, 0);
        model_scan(1010, 96, cars_with(600, 1, 5, -1, 0), h, ix);
        check("model_pin_nohit", int'(h), 0);
        model_scan(100, 128, cars_with(600, 2, 100, 6, 100), h, ix);
        check("model_pin_idx2", ix, 2);

        run_scan("basic", 100, 64, cars_with(600, 0, 80, -1, 0), 1'b0, 1, 0);
        run_scan("edge132", 100, 64, cars_with(600, 0, 132, -1, 0), 1'b0,
                 STICKY ? 1 : 0, 0);
        run_scan("edge131", 100, 64, cars_with(600, 0, 131, -1, 0), 1'b0, 1, 0);
        run_scan("nowrap", 1010, 96, cars_with(600, 1, 1000, -1, 0), 1'b0,
                 1, STICKY ? 0 : 1);
        run_scan("far", 1010, 96, cars_with(600, 1, 5, -1, 0), 1'b0,
                 STICKY ? 1 : 0, 0);
        run_scan("two_hits", 100, 128, cars_with(600, 2, 100, 6, 100), 1'b1,
                 1, STICKY ? 0 : 2);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.i_Frog_X = 10'd100;
        bus.i_Frog_Y = 9'd64;
        bus.i_Car_X  = cars_with(600, 0, 80, -1, 0);
        bus.i_Start  = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.o_Busy), 0);
        check("abort_done", int'(bus.o_Done), 0);
        check("abort_hit", int'(bus.o_Has_Collided), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < NC + 4; c++) begin
            @(negedge clk);
            if (bus.o_Done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        run_scan("after_rst", 200, 160, cars_with(600, 3, 210, -1, 0), 1'b0, 1, 3);
        run_scan("clean", 100, 64, cars_with(600, -1, 0, -1, 0), 1'b0,
                 STICKY ? 1 : 0, STICKY ? 3 : 0);
        repeat (5) @(negedge clk);
        check("hold_hit", int'(bus.o_Has_Collided), STICKY ? 1 : 0);
        check("hold_index", int'(bus.o_Hit_Index), STICKY ? 3 : 0);

        #2 rst_n = 1'b0;
        #1;
        check("final_rst_hit", int'(bus.o_Has_Collided), 0);
        check("final_rst_index", int'(bus.o_Hit_Index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
